dll_delay_ctrl: RTL and testbench
=================================

Name: dll_delay_ctrl

Overview:
- Lock controller for the digitally controlled delay line, a chain of N_CELLS delay cells, each with turn-point selects T/Tb.
- Converts phase-detector up/down decisions into a one-hot turn-point select.
- Acquires phase with a binary (SAR) search, then tracks with a filtered ±1 linear loop.
- Asserts locked once the loop is quiet; sits between the phase detector and the delay line.

Parameters:
N_CELLS, 16, number of delay cells in the line (power of 2, ≥4)
CODE_W, $clog2(N_CELLS), width of the delay code
SETTLE, 4, clock cycles to wait after any code change before a PD sample is accepted (≥1)
FILT, 4, up/down accumulator threshold for one tracking step (≥1)
LOCK_CNT, 8, consecutive accepted PD samples with no code change required to assert locked

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
en  in  1  enable; when low, the controller returns to IDLE
pd_valid  in  1  one-cycle strobe; pd_up/pd_dn are meaningful this cycle
pd_up  in  1  line too short, increase delay
pd_dn  in  1  line too long, decrease delay
code  out  CODE_W  current delay code, 0..N_CELLS-1
T  out  N_CELLS  one-hot turn-point select, T[code]=1
Tb  out  N_CELLS  bitwise ~T
locked  out  1  lock indicator
busy  out  1  high in SAR state
at_min  out  1  code==0 while tracking
at_max  out  1  code==N_CELLS-1 while tracking

Behaviour:
- All outputs registered. Reset (rst=1 at clk edge) and IDLE give:
  - code=0, T=1, Tb=~1, locked=0, busy=0, at_min=0, at_max=0;
  - accumulator=0, settle counter=0, lock counter=0, state=IDLE.
- rst wins over every other input, in any state, mid-search included.
- T and Tb are always derived from the registered code in the same cycle. Exactly one bit of T is high at all times.
- PD sample acceptance:
  - A sample is accepted only when pd_valid=1 and the settle counter is 0; pd_valid during settle is ignored.
  - Every code change loads the settle counter with SETTLE. It decrements each cycle to 0.
- FSM:
  - IDLE: en=1 moves to SAR. On entry: bit index k=CODE_W-1, code=1<<k, settle loaded, busy=1.
  - SAR, per bit k on an accepted sample:
    - if pd_dn=1 and pd_up=0: clear bit k; otherwise keep bit k (pd_up, both set, or neither set all keep it);
    - if k>0: set bit k-1, decrement k, reload settle;
    - if k=0: go to TRACK, busy=0, accumulator=0, lock counter=0, settle reloaded.
  - SAR consumes exactly CODE_W accepted samples.
  - TRACK, on an accepted sample:
    - pd_up only: acc+1; pd_dn only: acc-1; both or neither: acc unchanged, but the sample still counts toward lock.
    - acc==+FILT: code+1 unless at N_CELLS-1 (saturate, code held). acc=0.
    - acc==-FILT: code-1 unless at 0 (saturate). acc=0.
    - The accumulator is signed, with range -FILT..+FILT.
- Lock:
  - Any actual code change (increment or decrement, not a saturated no-op) clears the lock counter and locked, and reloads settle.
  - An accepted sample with no code change increments the lock counter, saturating at LOCK_CNT.
  - locked=1 when the counter equals LOCK_CNT. It is set the cycle after the LOCK_CNT-th sample.
  - locked is only ever 1 in TRACK.
- Saturation flags: at_min/at_max reflect saturation in TRACK only; both are 0 in IDLE/SAR.
- en=0 in any state: on the next edge, return to IDLE with reset values. en re-asserted later restarts SAR from scratch.
- No X on outputs after the first reset edge.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, en=0 -> code=0, T=16'h0001, Tb=16'hFFFE, locked=0, busy=0; en held 0 for 20 cycles -> no change.
- SAR acquisition (N_CELLS=16, SETTLE=4). PD model drives pd_up when code<11, pd_dn when code>11, both 0 at 11, pd_valid every cycle.
  - Trial codes are 8, 12, 10, 11; final code=11, T=16'h0800.
  - busy falls after exactly 4 accepted samples; no sample accepted inside any settle window.
- Tracking/filter: after lock at 11, model target moves to 13 -> code steps to 12 after 4 accepted up samples, then to 13 after 4 more. locked drops on the 11->12 change and reasserts 8 accepted samples after the last step.
- Saturation: target beyond the line (always pd_up) -> SAR yields 15; TRACK holds 15, at_max=1. locked asserts after 8 samples despite continuous pd_up (saturated step is not a change). Mirror case with always pd_dn -> code=0, at_min=1.
- Conflicting/ignored inputs: in TRACK, pd_up=pd_dn=1 on 8 valid strobes -> acc unchanged, locked=1. pd_valid pulses during settle -> no effect on code or accumulator.
- Abort paths:
  - en deasserted mid-SAR (after 2 samples) -> next cycle code=0, busy=0; re-enable -> full 4-step SAR repeats.
  - rst asserted while locked -> reset values next cycle.

Source files
------------

// File: rtl/dll_delay_ctrl.sv
`default_nettype none
// dll_delay_ctrl: SAR acquisition then filtered +/-1 tracking of a one-hot delay-line turn point.
// Rev 1.0 - initial release.
module dll_delay_ctrl #(
  parameter int N_CELLS  = 16,
  parameter int CODE_W   = $clog2(N_CELLS),
  parameter int SETTLE   = 4,
  parameter int FILT     = 4,
  parameter int LOCK_CNT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               pd_valid,
  input  logic               pd_up,
  input  logic               pd_dn,
  output logic [CODE_W-1:0]  code,
  output logic [N_CELLS-1:0] T,
  output logic [N_CELLS-1:0] Tb,
  output logic               locked,
  output logic               busy,
  output logic               at_min,
  output logic               at_max
);
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int ACC_W = $clog2(FILT + 1) + 1;
  localparam int LCK_W = $clog2(LOCK_CNT + 1);
  localparam int K_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  localparam logic [CODE_W-1:0]       CODE_MAX  = CODE_W'(N_CELLS - 1);
  localparam logic [SET_W-1:0]        SETTLE_LD = SET_W'(SETTLE);
  localparam logic [LCK_W-1:0]        LOCK_MAX  = LCK_W'(LOCK_CNT);
  localparam logic signed [ACC_W-1:0] ACC_ONE   = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_POS   = ACC_W'(FILT);
  localparam logic signed [ACC_W-1:0] ACC_NEG   = -ACC_POS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SAR   = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CODE_W-1:0]         code_q, code_d;
  logic [K_W-1:0]            k_q, k_d;
  logic [SET_W-1:0]          settle_q, settle_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [LCK_W-1:0]          lock_q, lock_d;
  logic                      locked_q, locked_d;
  logic                      busy_q, busy_d;
  logic                      at_min_q, at_min_d;
  logic                      at_max_q, at_max_d;

  logic                      accept;
  logic                      up_only;
  logic                      dn_only;
  logic signed [ACC_W-1:0]   acc_nx;
  logic                      step_up;
  logic                      step_dn;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    k_d      = k_q;
    acc_d    = acc_q;
    lock_d   = lock_q;
    settle_d = (settle_q != '0) ? settle_q - SET_W'(1) : '0;
    accept   = pd_valid && (settle_q == '0);
    up_only  = pd_up && !pd_dn;
    dn_only  = pd_dn && !pd_up;
    acc_nx   = acc_q;
    step_up  = 1'b0;
    step_dn  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d  = S_SAR;
          k_d      = K_W'(CODE_W - 1);
          code_d   = CODE_W'(1) << (CODE_W - 1);
          settle_d = SETTLE_LD;
        end
      end
      S_SAR: begin
        if (accept) begin
          // Only an unambiguous "too long" verdict clears the trial bit.
          if (dn_only) code_d[k_q] = 1'b0;
          if (k_q != '0) begin
            code_d[k_q - K_W'(1)] = 1'b1;
            k_d = k_q - K_W'(1);
          end else begin
            state_d = S_TRACK;
            acc_d   = '0;
            lock_d  = '0;
          end
          settle_d = SETTLE_LD;
        end
      end
      S_TRACK: begin
        if (accept) begin
          if (up_only)      acc_nx = acc_q + ACC_ONE;
          else if (dn_only) acc_nx = acc_q - ACC_ONE;
          step_up = (acc_nx == ACC_POS) && (code_q != CODE_MAX);
          step_dn = (acc_nx == ACC_NEG) && (code_q != '0);
          acc_d   = ((acc_nx == ACC_POS) || (acc_nx == ACC_NEG)) ? '0 : acc_nx;
          // A saturated step is not a change, so it still counts toward lock.
          if (step_up || step_dn) begin
            code_d   = step_up ? code_q + CODE_W'(1) : code_q - CODE_W'(1);
            lock_d   = '0;
            settle_d = SETTLE_LD;
          end else if (lock_q != LOCK_MAX) begin
            lock_d = lock_q + LCK_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!en) begin
      state_d  = S_IDLE;
      code_d   = '0;
      k_d      = '0;
      acc_d    = '0;
      lock_d   = '0;
      settle_d = '0;
    end

    busy_d   = (state_d == S_SAR);
    locked_d = (state_d == S_TRACK) && (lock_d == LOCK_MAX);
    at_min_d = (state_d == S_TRACK) && (code_d == '0);
    at_max_d = (state_d == S_TRACK) && (code_d == CODE_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      k_q      <= '0;
      settle_q <= '0;
      acc_q    <= '0;
      lock_q   <= '0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      at_min_q <= 1'b0;
      at_max_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      k_q      <= k_d;
      settle_q <= settle_d;
      acc_q    <= acc_d;
      lock_q   <= lock_d;
      locked_q <= locked_d;
      busy_q   <= busy_d;
      at_min_q <= at_min_d;
      at_max_q <= at_max_d;
    end
  end

  assign code   = code_q;
  assign T      = N_CELLS'(1) << code_q;
  assign Tb     = ~T;
  assign locked = locked_q;
  assign busy   = busy_q;
  assign at_min = at_min_q;
  assign at_max = at_max_q;

endmodule
`default_nettype wire

// File: tb/tb_dll_delay_ctrl.sv
`default_nettype none
// tb_dll_delay_ctrl: stimulus queues the expected output events, a monitor pops and checks
// each time the DUT output bundle changes (including cycles elapsed since the previous change).
module tb_dll_delay_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pd_valid;
  logic        pd_up;
  logic        pd_dn;
  logic [3:0]  code;
  logic [15:0] T;
  logic [15:0] Tb;
  logic        locked;
  logic        busy;
  logic        at_min;
  logic        at_max;

  dll_delay_ctrl #(
    .N_CELLS(16), .CODE_W(4), .SETTLE(4), .FILT(4), .LOCK_CNT(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pd_valid(pd_valid), .pd_up(pd_up), .pd_dn(pd_dn),
    .code(code), .T(T), .Tb(Tb), .locked(locked), .busy(busy), .at_min(at_min), .at_max(at_max)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] code;
    logic       locked;
    logic       busy;
    logic       at_min;
    logic       at_max;
    int         gap;
  } ev_t;

  ev_t   exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  localparam int M_MODEL = 0;
  localparam int M_MAN   = 1;
  int   mode   = M_MAN;
  int   target = 0;
  logic man_v  = 1'b0;
  logic man_u  = 1'b0;
  logic man_d  = 1'b0;

  // Phase-detector driver: a model comparing the code with a target, or manual strobes.
  initial begin
    pd_valid = 1'b0;
    pd_up    = 1'b0;
    pd_dn    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == M_MODEL) begin
        pd_valid = 1'b1;
        pd_up    = (int'(code) < target);
        pd_dn    = (int'(code) > target);
      end else begin
        pd_valid = man_v;
        pd_up    = man_u;
        pd_dn    = man_d;
      end
    end
  end

  // Monitor
  initial begin
    logic [39:0] prev;
    logic [39:0] cur;
    logic [15:0] texp;
    int          cyc;
    int          last;
    int          g;
    ev_t         e;
    string       nm;
    prev = 'x;
    cyc  = 0;
    last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {code, T, Tb, locked, busy, at_min, at_max};
      if (cur !== prev) begin
        g    = cyc - last;
        last = cyc;
        prev = cur;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: code=%0d locked=%0b busy=%0b at_min=%0b at_max=%0b, required no output change",
                   code, locked, busy, at_min, at_max);
        end else begin
          e    = exp_q.pop_front();
          nm   = name_q.pop_front();
          texp = 16'd1 << e.code;
          if (code !== e.code || T !== texp || Tb !== ~texp || locked !== e.locked ||
              busy !== e.busy || at_min !== e.at_min || at_max !== e.at_max ||
              (e.gap >= 0 && g != e.gap)) begin
            bad++;
            $display("FAIL %s: got code=%0d T=%h Tb=%h locked=%0b busy=%0b at_min=%0b at_max=%0b gap=%0d; required code=%0d T=%h Tb=%h locked=%0b busy=%0b at_min=%0b at_max=%0b gap=%0d",
                     nm, code, T, Tb, locked, busy, at_min, at_max, g,
                     e.code, texp, ~texp, e.locked, e.busy, e.at_min, e.at_max, e.gap);
          end
        end
      end
      if (!rst) begin
        total++;
        if (!$onehot(T) || Tb !== ~T || (locked && busy)) begin
          bad++;
          $display("FAIL invariant: got T=%h Tb=%h locked=%0b busy=%0b, required one-hot T, Tb=~T, not locked while busy",
                   T, Tb, locked, busy);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_ev(input string nm, input int c, input int l, input int b,
                           input int mn, input int mx, input int gap);
    ev_t e;
    e.code   = c[3:0];
    e.locked = (l != 0);
    e.busy   = (b != 0);
    e.at_min = (mn != 0);
    e.at_max = (mx != 0);
    e.gap    = gap;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic drive(input logic v, input logic u, input logic d);
    man_v = v;
    man_u = u;
    man_d = d;
    tick();
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d events still pending after %0d cycles, required 0",
               nm, exp_q.size(), budget);
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    expect_ev("reset", 0, 0, 0, 0, 0, -1);
    tick();
    tick();
    rst = 1'b0;
    repeat (20) tick();
    wait_drain("reset", 10);

    // SAR towards 11, then lock with the PD quiet.
    target = 11;
    mode   = M_MODEL;
    expect_ev("sar_trial8",  8,  0, 1, 0, 0, -1);
    expect_ev("sar_trial12", 12, 0, 1, 0, 0, 5);
    expect_ev("sar_trial10", 10, 0, 1, 0, 0, 5);
    expect_ev("sar_trial11", 11, 0, 1, 0, 0, 5);
    expect_ev("sar_done11",  11, 0, 0, 0, 0, 5);
    expect_ev("lock11",      11, 1, 0, 0, 0, 12);
    en = 1'b1;
    wait_drain("sar11", 200);

    // Target moves to 13: two filtered steps, then relock.
    expect_ev("track_step12", 12, 0, 0, 0, 0, -1);
    expect_ev("track_step13", 13, 0, 0, 0, 0, 8);
    expect_ev("relock13",     13, 1, 0, 0, 0, 12);
    target = 13;
    wait_drain("track13", 200);

    // Manual strobes: 3 ups, 8 conflicting, then ups including some inside settle.
    mode = M_MAN;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) begin
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
    repeat (8) begin
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
    end
    expect_ev("step14_after_both", 14, 0, 0, 0, 0, -1);
    repeat (5) drive(1'b1, 1'b1, 1'b0);
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    expect_ev("step15_settle_ignored", 15, 0, 0, 0, 1, 8);
    expect_ev("lock15_saturated",      15, 1, 0, 0, 1, 12);
    drive(1'b1, 1'b1, 1'b0);
    target = 20;
    mode   = M_MODEL;
    wait_drain("manual", 200);

    expect_ev("abort_locked_idle", 0, 0, 0, 0, 0, -1);
    en = 1'b0;
    tick();
    tick();
    wait_drain("abort_locked", 20);

    // Always pd_dn: SAR walks down to 0, TRACK saturates at the bottom.
    target = -1;
    expect_ev("dn_trial8",   8, 0, 1, 0, 0, -1);
    expect_ev("dn_trial4",   4, 0, 1, 0, 0, 5);
    expect_ev("dn_trial2",   2, 0, 1, 0, 0, 5);
    expect_ev("dn_trial1",   1, 0, 1, 0, 0, 5);
    expect_ev("dn_done0",    0, 0, 0, 1, 0, 5);
    expect_ev("dn_lock_min", 0, 1, 0, 1, 0, 12);
    en = 1'b1;
    wait_drain("sar_dn", 200);
    expect_ev("dn_idle", 0, 0, 0, 0, 0, -1);
    en = 1'b0;
    tick();
    tick();
    wait_drain("dn_idle", 20);

    // Always pd_up, abort after two samples, then a full SAR to 15.
    target = 20;
    expect_ev("part_trial8",  8,  0, 1, 0, 0, -1);
    expect_ev("part_trial12", 12, 0, 1, 0, 0, 5);
    expect_ev("part_trial14", 14, 0, 1, 0, 0, 5);
    en = 1'b1;
    wait_drain("sar_part", 100);
    expect_ev("mid_sar_abort", 0, 0, 0, 0, 0, -1);
    en = 1'b0;
    repeat (3) tick();
    wait_drain("mid_sar_abort", 20);
    expect_ev("up_trial8",   8,  0, 1, 0, 0, -1);
    expect_ev("up_trial12",  12, 0, 1, 0, 0, 5);
    expect_ev("up_trial14",  14, 0, 1, 0, 0, 5);
    expect_ev("up_trial15",  15, 0, 1, 0, 0, 5);
    expect_ev("up_done15",   15, 0, 0, 0, 1, 5);
    expect_ev("up_lock_max", 15, 1, 0, 0, 1, 12);
    en = 1'b1;
    wait_drain("sar_up", 200);

    // Reset while locked, with en still high.
    expect_ev("reset_locked", 0, 0, 0, 0, 0, -1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    en  = 1'b0;
    repeat (5) tick();
    wait_drain("reset_locked", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
